// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the FSM state encoding plus the NOP and reset-PC defaults.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// Hold buffer for the fetch stage: a load-enable instruction register.
// It keeps an acked word alive while decode is stalled.
module fetch_hold_buf
    import fetch_pkg::*;
#(
    parameter logic [31:0] RST_VAL = FETCH_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] data_q;
    logic [31:0] data_d;

    // Next value: load on enable, otherwise keep
    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    // Storage register, cleared to the NOP word on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a valid/ack memory port, stall hold
// buffer and redirect handling that drops in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  req_addr_q;
    logic [31:0]  req_addr_d;
    logic [31:0]  pc_plus4;
    logic         hold_en;
    logic [31:0]  hold_instr;

    assign pc_plus4 = pc_q + 32'd4;

    fetch_hold_buf #(
        .RST_VAL(NOP_INSTR)
    ) u_hold_buf (
        .clk(clk),
        .rst(rst),
        .en (hold_en),
        .d  (imem_rdata),
        .q  (hold_instr)
    );

    // Next-state, PC/request address update and stage outputs
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_en    = 1'b0;
        imem_req   = 1'b1;
        ValidF     = 1'b0;
        InstrF     = NOP_INSTR;
        unique case (state_q)
            FETCH: begin
                if (Flush) begin
                    // Redirect wins; any response this cycle is stale
                    pc_d = PCTargetE;
                    if (imem_ack) begin
                        req_addr_d = PCTargetE;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (imem_ack) begin
                    ValidF = 1'b1;
                    InstrF = imem_rdata;
                    if (Stall) begin
                        hold_en = 1'b1;
                        state_d = HOLD;
                    end else begin
                        pc_d       = pc_plus4;
                        req_addr_d = pc_plus4;
                    end
                end
            end
            HOLD: begin
                imem_req = 1'b0;
                ValidF   = 1'b1;
                InstrF   = hold_instr;
                if (Flush) begin
                    pc_d       = PCTargetE;
                    req_addr_d = PCTargetE;
                    state_d    = FETCH;
                end else if (!Stall) begin
                    pc_d       = pc_plus4;
                    req_addr_d = pc_plus4;
                    state_d    = FETCH;
                end
            end
            DISCARD: begin
                // Keep the old request up until memory acks it
                if (Flush) begin
                    pc_d = PCTargetE;
                end
                if (imem_ack) begin
                    req_addr_d = pc_d;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, PC and request address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign imem_addr = req_addr_q;
    assign PCF       = pc_q;
    assign PCPlus4F  = pc_plus4;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction driven on InstrF when no valid instruction is present.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port Stall, input, 1, hazard-unit request to hold the fetch stage.
REQ-006 SHALL have port Flush, input, 1, redirect request from execute (branch or jump taken).
REQ-007 SHALL have port PCTargetE, input, 32, redirect target, sampled when Flush=1.
REQ-008 SHALL have port imem_req, output, 1, instruction-memory request valid.
REQ-009 SHALL have port imem_addr, output, 32, request address.
REQ-010 SHALL have port imem_ack, input, 1, memory response valid; qualified by imem_req.
REQ-011 SHALL have port imem_rdata, input, 32, response instruction word.
REQ-012 SHALL have port InstrF, output, 32, instruction presented to the fetch/decode register.
REQ-013 SHALL have port PCF, output, 32, PC of the instruction on InstrF.
REQ-014 SHALL have port PCPlus4F, output, 32, PCF+4, wrapping modulo 2^32.
REQ-015 SHALL have port ValidF, output, 1, high when InstrF holds a real instruction.

Function
REQ-016 SHALL implement FSM states FETCH, HOLD and DISCARD.
REQ-017 Request rule: once imem_req is asserted, it and imem_addr SHALL stay stable until the cycle imem_ack=1; ack in the same cycle as the first req cycle SHALL be legal (zero-wait memory).
REQ-018 ReqAddr register: imem_addr = ReqAddr; imem_req=1 in FETCH and DISCARD, 0 in HOLD.
REQ-019 FETCH, ack=0, Flush=0: ValidF=0, InstrF=NOP_INSTR, state holds.
REQ-020 FETCH, ack=1, Flush=0, Stall=0: ValidF=1, InstrF=imem_rdata; next cycle PCF=ReqAddr=PCF+4; stay FETCH.
REQ-021 FETCH, ack=1, Flush=0, Stall=1: ValidF=1, InstrF=imem_rdata; hold buffer captures imem_rdata; next state HOLD; PCF unchanged.
REQ-022 FETCH, Flush=1, ack=1: data dropped (ValidF=0); PCF=ReqAddr=PCTargetE next cycle; stay FETCH.
REQ-023 FETCH, Flush=1, ack=0: ValidF=0; PCF=PCTargetE next cycle; ReqAddr unchanged; next state DISCARD.
REQ-024 HOLD: ValidF=1, InstrF=hold buffer. Flush=1 -> PCF=ReqAddr=PCTargetE, go FETCH. Flush=0, Stall=0 -> PCF=ReqAddr=PCF+4, go FETCH. Stall=1 -> remain.
REQ-025 DISCARD: ValidF=0, InstrF=NOP_INSTR. ack=1 -> ReqAddr=PCF, go FETCH. Flush=1 (with or without ack) -> PCF=PCTargetE.
REQ-026 Flush SHALL dominate Stall in every state.
REQ-027 PCPlus4F SHALL be combinational PCF+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-028 imem_rdata SHALL be ignored whenever ack=0 or req=0.

Reset
REQ-029 Asserting rst SHALL immediately force state=FETCH, PCF=ReqAddr=RESET_PC, hold buffer=NOP_INSTR, ValidF=0, and imem_req=1 after release.
REQ-030 rst mid-request SHALL abandon the outstanding request; the memory shares rst, so no stale ack is expected.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state enum, the NOP_INSTR value and the RESET_PC default.
REQ-032 Sub-module fetch_hold_buf (32-bit load-enable register with async reset to NOP_INSTR) SHALL implement the hold buffer.

Verification
REQ-033 Zero-wait memory, rst released, Stall=Flush=0 -> PCF 0,4,8,... on consecutive cycles; ValidF=1 each cycle.
REQ-034 Two-cycle-latency memory -> ValidF alternates 0,1; InstrF=NOP_INSTR on the 0 cycles; imem_addr stable while waiting.
REQ-035 Ack at PC=8 with Stall=1 for 3 cycles -> InstrF held at mem[8] and req=0 for 3 cycles; next address 12 after Stall drops.
REQ-036 Flush with PCTargetE=32'h100 while request to 16 is pending -> DISCARD; ack for 16 dropped (ValidF=0); next request address 32'h100.
REQ-037 Flush and Stall both high in HOLD -> next request at PCTargetE; Stall ignored.
REQ-038 rst pulse mid-wait at PC=32'h40 -> PCF=0 and ValidF=0 immediately; fetch resumes at 0.
